// File: rtl/tag_array_sa_if.sv
// Request/response bundle between the cache controller and tag_array_sa.
// resp_perr exists only when TAG_PARITY_EN is defined.
interface tag_array_sa_if #(
   parameter int ADDR_W  = 16,
   parameter int INDEX_W = 4,
   parameter int WAYS    = 2
);
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W = ADDR_W - INDEX_W;

   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic              resp_hit;
   logic [WAY_W-1:0]  resp_way;
   logic              resp_evict;
   logic [TAG_W-1:0]  resp_evict_tag;
   logic              flush_busy;
`ifdef TAG_PARITY_EN
   logic              resp_perr;
`endif

   modport master (
      output req_valid, req_op, req_addr,
      input  req_ready, resp_valid, resp_hit, resp_way, resp_evict,
             resp_evict_tag, flush_busy
`ifdef TAG_PARITY_EN
      , input resp_perr
`endif
   );

   modport slave (
      input  req_valid, req_op, req_addr,
      output req_ready, resp_valid, resp_hit, resp_way, resp_evict,
             resp_evict_tag, flush_busy
`ifdef TAG_PARITY_EN
      , output resp_perr
`endif
   );
endinterface

// File: rtl/tag_array_sa.sv
// Set-associative tag/valid/LRU store with lookup, fill and invalidate.
// Optional TAG_PARITY_EN adds even parity per entry and the resp_perr output.
//
// state | meaning
// FLUSH | walking sets after reset, clearing valid bits and LRU ages
// IDLE  | accepting one request per cycle, response registered next cycle
module tag_array_sa #(
   parameter int ADDR_W  = 16,
   parameter int INDEX_W = 4,
   parameter int WAYS    = 2
) (
   input logic          clk,
   input logic          reset,
   tag_array_sa_if.slave bus
);
   localparam int SETS  = 1 << INDEX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W = ADDR_W - INDEX_W;

   typedef enum logic {FLUSH, IDLE} state_t;

   state_t               state, stateNext;
   logic [INDEX_W-1:0]   flushCnt, flushCntNext;
   logic                 reqReady, flushBusy;

   logic [TAG_W-1:0]     tagMem   [SETS][WAYS];
   logic [WAYS-1:0]      validMem [SETS];
   logic [WAY_W-1:0]     ageMem   [SETS][WAYS];
`ifdef TAG_PARITY_EN
   logic [WAYS-1:0]      parMem   [SETS];
`endif

   logic [TAG_W-1:0]     reqTag;
   logic [INDEX_W-1:0]   reqIdx;
   logic                 accept, isFill, isInv;
   logic [WAYS-1:0]      wayOk, match, perrVec;
   logic                 hit, freeFound;
   logic [WAY_W-1:0]     hitWay, freeWay, lruWay, victimWay, touchWay;
   logic                 doTouch;
   logic [WAY_W-1:0]     ageNext [WAYS];

   logic                 respValid, respHit, respEvict, respPerr;
   logic [WAY_W-1:0]     respWay;
   logic [TAG_W-1:0]     respEvictTag;

   assign reqTag = bus.req_addr[ADDR_W-1:INDEX_W];
   assign reqIdx = bus.req_addr[INDEX_W-1:0];
   assign isFill = (bus.req_op == 2'b01);
   assign isInv  = (bus.req_op == 2'b10);
   assign accept = bus.req_valid & reqReady & ~reset;

   always_comb begin
      stateNext    = state;
      flushCntNext = flushCnt;
      reqReady     = (state == IDLE);
      flushBusy    = (state == FLUSH);
      case (state)
         FLUSH: begin
            flushCntNext = flushCnt + 1'b1;
            if (flushCnt == INDEX_W'(SETS - 1)) stateNext = IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FLUSH;
         flushCnt <= '0;
      end else begin
         state    <= stateNext;
         flushCnt <= flushCntNext;
      end
   end

   // A way whose stored parity disagrees with its tag counts as invalid.
   always_comb begin
      wayOk     = '0;
      match     = '0;
      perrVec   = '0;
      hit       = 1'b0;
      hitWay    = '0;
      freeFound = 1'b0;
      freeWay   = '0;
      lruWay    = '0;
      for (int w = 0; w < WAYS; w++) begin
`ifdef TAG_PARITY_EN
         perrVec[w] = validMem[reqIdx][w] & (parMem[reqIdx][w] != ^tagMem[reqIdx][w]);
`endif
         wayOk[w] = validMem[reqIdx][w] & ~perrVec[w];
         match[w] = wayOk[w] & (tagMem[reqIdx][w] == reqTag);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) begin
            hit    = 1'b1;
            hitWay = WAY_W'(w);
         end
         if (!wayOk[w]) begin
            freeFound = 1'b1;
            freeWay   = WAY_W'(w);
         end
         if (ageMem[reqIdx][w] == WAY_W'(WAYS - 1)) lruWay = WAY_W'(w);
      end
   end

   assign victimWay = freeFound ? freeWay : lruWay;
   assign touchWay  = hit ? hitWay : victimWay;
   assign doTouch   = accept & ((!isInv & hit) | isFill);

   always_comb begin
      for (int v = 0; v < WAYS; v++) begin
         ageNext[v] = ageMem[reqIdx][v];
         if (WAY_W'(v) == touchWay)
            ageNext[v] = '0;
         else if (ageMem[reqIdx][v] < ageMem[reqIdx][touchWay])
            ageNext[v] = ageMem[reqIdx][v] + 1'b1;
      end
   end

   // Flush loads the identity permutation so ages stay a permutation of 0..WAYS-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == FLUSH) begin
            validMem[flushCnt] <= '0;
            for (int w = 0; w < WAYS; w++) ageMem[flushCnt][w] <= WAY_W'(w);
         end else if (accept) begin
            if (isFill && !hit) begin
               tagMem[reqIdx][victimWay]   <= reqTag;
               validMem[reqIdx][victimWay] <= 1'b1;
`ifdef TAG_PARITY_EN
               parMem[reqIdx][victimWay]   <= ^reqTag;
`endif
            end
            if (isInv && hit) validMem[reqIdx][hitWay] <= 1'b0;
            if (doTouch)
               for (int w = 0; w < WAYS; w++) ageMem[reqIdx][w] <= ageNext[w];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         respValid    <= 1'b0;
         respHit      <= 1'b0;
         respWay      <= '0;
         respEvict    <= 1'b0;
         respEvictTag <= '0;
         respPerr     <= 1'b0;
      end else begin
         respValid <= accept;
         if (accept) begin
            respHit      <= hit;
            respWay      <= isFill ? touchWay : hitWay;
            respEvict    <= isFill & ~hit & wayOk[victimWay];
            respEvictTag <= (isFill & ~hit & wayOk[victimWay]) ? tagMem[reqIdx][victimWay] : '0;
            respPerr     <= |perrVec;
         end
      end
   end

   assign bus.req_ready      = reqReady;
   assign bus.flush_busy     = flushBusy;
   assign bus.resp_valid     = respValid;
   assign bus.resp_hit       = respHit;
   assign bus.resp_way       = respWay;
   assign bus.resp_evict     = respEvict;
   assign bus.resp_evict_tag = respEvictTag;
`ifdef TAG_PARITY_EN
   assign bus.resp_perr      = respPerr;
`else
   logic unusedPerr;
   assign unusedPerr = respPerr;
`endif
endmodule

// File: tb/tb_tag_array_sa.sv
// Scoreboard bench for tag_array_sa: directed requests push expected responses,
// a negedge monitor pops and compares them whenever resp_valid is seen.
module tb_tag_array_sa;
   localparam int ADDR_W  = 16;
   localparam int INDEX_W = 4;
   localparam int WAYS    = 2;
   localparam int WAY_W   = 1;
   localparam int TAG_W   = ADDR_W - INDEX_W;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tag_array_sa_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) bus();

   tag_array_sa #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      string            name;
      logic             hit;
      logic [WAY_W-1:0] way;
      logic             evict;
      logic [TAG_W-1:0] evictTag;
      logic             perr;
   } exp_t;

   exp_t expQ[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (bus.resp_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid 1, expected no response");
         end else begin
            cur = expQ.pop_front();
            check({cur.name, "_hit"}, 32'(bus.resp_hit), 32'(cur.hit));
            check({cur.name, "_way"}, 32'(bus.resp_way), 32'(cur.way));
            check({cur.name, "_evict"}, 32'(bus.resp_evict), 32'(cur.evict));
            if (cur.evict)
               check({cur.name, "_evict_tag"}, 32'(bus.resp_evict_tag), 32'(cur.evictTag));
`ifdef TAG_PARITY_EN
            check({cur.name, "_perr"}, 32'(bus.resp_perr), 32'(cur.perr));
`endif
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input string name,
                        input logic hit, input logic [WAY_W-1:0] way, input logic evict,
                        input logic [TAG_W-1:0] evictTag, input logic perr);
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      check({name, "_ready"}, 32'(bus.req_ready), 32'd1);
      e.name = name; e.hit = hit; e.way = way; e.evict = evict; e.evictTag = evictTag; e.perr = perr;
      expQ.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic waitFlush(input string name);
      int   cnt = 0;
      logic readyBad = 1'b0;
      while (bus.flush_busy === 1'b1 && cnt < 100) begin
         if (bus.req_ready !== 1'b0) readyBad = 1'b1;
         cnt++;
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      check({name, "_flush_cycles"}, 32'(cnt), 32'd16);
      check({name, "_ready_during_flush"}, 32'(readyBad), 32'd0);
      check({name, "_ready_after_flush"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_addr  = '0;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
      check("rst_resp_way", 32'(bus.resp_way), 32'd0);
      check("rst_resp_evict", 32'(bus.resp_evict), 32'd0);
      check("rst_resp_evict_tag", 32'(bus.resp_evict_tag), 32'd0);
      check("rst_flush_busy", 32'(bus.flush_busy), 32'd1);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
`ifdef TAG_PARITY_EN
      check("rst_resp_perr", 32'(bus.resp_perr), 32'd0);
`endif
      reset = 1'b0;
      waitFlush("init");

      issue(2'b01, 16'h1230, "fill_1230",     1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b00, 16'h1230, "look_1230",     1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b00, 16'h4560, "look_4560",     1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b01, 16'h2230, "fill_2230",     1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
      issue(2'b00, 16'h1230, "look_1230b",    1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b01, 16'h3230, "fill_3230",     1'b0, 1'b1, 1'b1, 12'h223, 1'b0);
      issue(2'b00, 16'h2230, "look_2230",     1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b00, 16'h3230, "look_3230",     1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
      issue(2'b10, 16'h1230, "inv_1230",      1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b00, 16'h1230, "look_1230c",    1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b01, 16'h5230, "fill_5230",     1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b01, 16'h5230, "fill_5230_hit", 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b10, 16'h7777, "inv_miss",      1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b11, 16'h5230, "rsvd_look",     1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b01, 16'h00F1, "fill_s1_a",     1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b01, 16'h10F1, "fill_s1_b",     1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
      issue(2'b01, 16'h20F1, "fill_s1_c",     1'b0, 1'b0, 1'b1, 12'h00F, 1'b0);
      idle(3);

      // Reset lands on the same edge that would accept a fill.
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_addr  = 16'hABC5;
      reset         = 1'b1;
      @(negedge clk);
      check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("midrst_flush_busy", 32'(bus.flush_busy), 32'd1);
      reset = 1'b0;
      waitFlush("midrst");

      issue(2'b00, 16'hABC5, "post_look_abc5", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b00, 16'h5230, "post_look_5230", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      issue(2'b01, 16'h5230, "post_fill_5230", 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      idle(3);

`ifdef TAG_PARITY_EN
      dut.parMem[0][0] = ~dut.parMem[0][0];
      issue(2'b00, 16'h5230, "perr_look",     1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
      issue(2'b01, 16'h6230, "perr_fill",     1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
      issue(2'b00, 16'h6230, "perr_look_new", 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      idle(3);
`endif

      t = 0;
      while (expQ.size() != 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("queue_drained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
